div_stim_gen: RTL and testbench



---
 rtl/div_pkg.sv | 34 +++
 rtl/div_residue.sv | 43 ++++
 rtl/div_stim_gen.sv | 159 +++++++++++++++
 tb/tb_div_stim_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the divisibility stimulus generator:
//   - divisor select encodings carried on the sel port
//   - FSM state enumeration for div_stim_gen
//   - step_of(): distance between consecutive multiples for a select code
package div_pkg;

  localparam logic [1:0] SEL_ALL = 2'b00;
  localparam logic [1:0] SEL_BY2 = 2'b01;
  localparam logic [1:0] SEL_BY3 = 2'b10;
  localparam logic [1:0] SEL_BY6 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Step to the next multiple; equal to the selected divisor.
  function automatic logic [2:0] step_of(input logic [1:0] sel);
    logic [2:0] step;
    step = 3'd1;
    case (sel)
      SEL_ALL: step = 3'd1;
      SEL_BY2: step = 3'd2;
      SEL_BY3: step = 3'd3;
      SEL_BY6: step = 3'd6;
      default: step = 3'd1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/div_residue.sv
// div_residue
// Candidate counter with incrementally tracked divisibility. The parity comes
// straight from bit 0 of the candidate; the mod-3 residue is kept as its own
// 0..2 counter that advances in lock step with the candidate, so no divider
// is needed.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   clear   in   restart at candidate 0 / residue 0
//   inc     in   advance candidate and residue by one
//   cand    out  current candidate value
//   res3    out  cand mod 3
//   is_by2  out  cand is even
//   is_by3  out  cand is a multiple of 3
module div_residue
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] cand,
  output logic [1:0]       res3,
  output logic             is_by2,
  output logic             is_by3
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cand <= '0;
      res3 <= 2'd0;
    end else if (inc) begin
      cand <= cand + WIDTH'(1);
      res3 <= (res3 == 2'd2) ? 2'd0 : res3 + 2'd1;
    end
  end

  assign is_by2 = ~cand[0];
  assign is_by3 = (res3 == 2'd0);

endmodule

// File: rtl/div_stim_gen.sv
// div_stim_gen
// Emits every value in 0..LIMIT divisible by the selected divisor (1, 2, 3
// or 6) over a valid/ready stream. One candidate is evaluated per cycle in
// SCAN; a match is registered onto the output and held in HOLD until the
// consumer accepts it.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, highest priority
//   start      in   begin a run (only honoured in IDLE)
//   sel        in   divisor select, latched on start
//   out_valid  out  out_data holds a multiple
//   out_ready  in   consumer accepts the beat
//   out_data   out  current multiple
//   out_last   out  final beat of the run
//   busy       out  high in SCAN and HOLD
//   done       out  one-cycle pulse at the end of a run
//   count      out  beats accepted in the current / most recent run
module div_stim_gen
  import div_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LIMIT = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       sel_q;
  logic             res_clear;
  logic             res_inc;
  logic [WIDTH-1:0] cand;
  logic [1:0]       res3;
  logic             is_by2;
  logic             is_by3;
  logic             match;
  logic             at_limit;
  logic             handshake;

  div_residue #(
    .WIDTH (WIDTH)
  ) u_residue (
    .clk    (clk),
    .rst    (rst),
    .clear  (res_clear),
    .inc    (res_inc),
    .cand   (cand),
    .res3   (res3),
    .is_by2 (is_by2),
    .is_by3 (is_by3)
  );

  // sel bit 0 demands an even candidate, sel bit 1 a multiple of 3; both
  // together give the by-6 rule and neither gives "every value".
  assign match     = (~sel_q[0] | is_by2) & (~sel_q[1] | is_by3);
  assign at_limit  = (cand == LIM);
  assign handshake = (state_q == ST_HOLD) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, plus the candidate clear/advance strobes that go with each
  // transition. The candidate only advances when it is below LIMIT, so it
  // never runs past the scan range.
  always_comb begin
    state_d   = state_q;
    res_clear = 1'b0;
    res_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SCAN;
          res_clear = 1'b1;
        end
      end
      ST_SCAN: begin
        if (match) begin
          state_d = ST_HOLD;
        end else if (at_limit) begin
          state_d = ST_DONE;
        end else begin
          res_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (at_limit) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
            res_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state.
  always_comb begin
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q == ST_SCAN) || (state_q == ST_HOLD);
    done      = (state_q == ST_DONE);
  end

  // Output beat register, latched select and accepted-beat counter.
  // out_last compares in WIDTH+1 bits so cand+step cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= SEL_ALL;
      out_data <= '0;
      out_last <= 1'b0;
      count    <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        sel_q <= sel;
        count <= '0;
      end
      if ((state_q == ST_SCAN) && match) begin
        out_data <= cand;
        out_last <= (({1'b0, cand} + (WIDTH+1)'(step_of(sel_q))) > {1'b0, LIM});
      end
      if (handshake) begin
        count <= count + WIDTH'(1);
      end
    end
  end

  // The residue counter and its decoded flag must always agree.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (is_by3 == (res3 == 2'd0) && res3 != 2'd3);
    end
  end

endmodule

// File: tb/tb_div_stim_gen.sv
// tb_div_stim_gen
// Scoreboard bench for div_stim_gen. Each run pushes the expected beats,
// computed from plain modulo arithmetic, into a queue; an independent monitor
// compares every presented beat, its stability under back-pressure, the idle
// gap before it and the end-of-run done pulse.
module tb_div_stim_gen;

  localparam int WIDTH = 4;
  localparam int LIMIT = 11;

  typedef struct {
    int data;
    int last;
    int gap;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   exp_count;
  int   run_div;
  int   done_seen;
  int   ready_ctl;

  div_stim_gen #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: every v in 0..LIMIT with v % div == 0, in order.
  task automatic pushRun(input logic [1:0] s);
    int   div;
    int   prev;
    int   n;
    exp_t e;
    div  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 3 : 6;
    prev = -1;
    n    = 0;
    for (int v = 0; v <= LIMIT; v++) begin
      if (v % div == 0) begin
        e.data = v;
        e.last = (v + div > LIMIT) ? 1 : 0;
        e.gap  = v - prev;
        prev   = v;
        exp_q.push_back(e);
        n++;
      end
    end
    exp_count = n;
    run_div   = div;
  endtask

  // out_ready driver: 0 = always high, 1 = random, 2 = held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_ctl)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares presented beats against the scoreboard head.
  initial begin
    int tracking;
    int low;
    int done_wait;
    tracking  = 0;
    low       = 0;
    done_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        tracking  = 0;
        done_wait = 0;
      end else begin
        if (done_wait > 0) begin
          done_wait--;
          if (done_wait == 0) checkOutput("done_timing", int'(done), 1);
        end
        if (done) done_seen++;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", int'(out_data), -1);
          end else begin
            if (tracking != 0) begin
              checkOutput("gap", low, exp_q[0].gap);
              tracking = 0;
            end
            checkOutput("data", int'(out_data), exp_q[0].data);
            checkOutput("last", int'(out_last), exp_q[0].last);
            if (out_ready) begin
              checkOutput("loopback", ((int'(out_data) % run_div) == 0) ? 1 : 0, 1);
              if (exp_q[0].last != 0) done_wait = LIMIT - exp_q[0].data + 1;
              void'(exp_q.pop_front());
              tracking = 1;
              low      = 0;
            end
          end
        end else if (tracking != 0) begin
          if (done) tracking = 0;
          else low++;
        end
        if (start && !busy && !done) begin
          tracking = 1;
          low      = 0;
        end
      end
    end
  end

  // One complete run. disturb >= 0 pulses start with sel=10 when that value
  // is on the bus, which the DUT must ignore.
  task automatic applyStimulus(input logic [1:0] s, input int rmode, input int disturb);
    int cycles;
    int finished;
    int fired;
    @(negedge clk);
    ready_ctl = rmode;
    done_seen = 0;
    pushRun(s);
    @(posedge clk);
    #1;
    start = 1'b1;
    sel   = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    sel   = 2'($urandom);
    cycles   = 0;
    finished = 0;
    fired    = 0;
    while (finished == 0 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (done) finished = 1;
      else if (disturb >= 0 && fired == 0 && out_valid && int'(out_data) == disturb) begin
        fired = 1;
        @(posedge clk);
        #1;
        start = 1'b1;
        sel   = 2'b10;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    if (finished == 0) checkOutput("done_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("count", int'(count), exp_count);
    checkOutput("done_pulses", done_seen, 1);
    checkOutput("beats_left", exp_q.size(), 0);
    checkOutput("idle_busy", int'(busy), 0);
    if (disturb >= 0) checkOutput("disturb_seen", fired, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_data"},  int'(out_data),  0);
    checkOutput({tag, "_last"},  int'(out_last),  0);
    checkOutput({tag, "_busy"},  int'(busy),      0);
    checkOutput({tag, "_done"},  int'(done),      0);
    checkOutput({tag, "_count"}, int'(count),     0);
  endtask

  // Stall beat 6 of a by-3 run, then reset while it is pending.
  task automatic resetMidRun();
    int cycles;
    int found;
    @(negedge clk);
    ready_ctl = 0;
    pushRun(2'b10);
    @(posedge clk);
    #1;
    start = 1'b1;
    sel   = 2'b10;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    found  = 0;
    while (found == 0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (out_valid && int'(out_data) == 3 && ready_ctl == 0) ready_ctl = 2;
      if (out_valid && int'(out_data) == 6 && ready_ctl == 2) found = 1;
    end
    checkOutput("hold_at_6", found, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("midrun_reset");
    ready_ctl = 0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_count = 0;
    run_div   = 1;
    done_seen = 0;
    ready_ctl = 0;
    rst       = 1'b1;
    start     = 1'b0;
    sel       = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    applyStimulus(2'b01, 0, -1);
    applyStimulus(2'b10, 0, -1);
    applyStimulus(2'b11, 0, -1);
    applyStimulus(2'b00, 1, -1);
    applyStimulus(2'b01, 0, 4);
    resetMidRun();
    applyStimulus(2'b11, 0, -1);
    for (int r = 0; r < 6; r++) begin
      applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
